// File: rtl/pipe_mux_sel.sv
// pipe_mux_sel
//   N-way, WIDTH-bit operand select feeding a registered pipeline stage with a
//   valid/ready handshake and a 2-entry skid buffer (main + skid register).
//   Full throughput without a combinational out_ready -> in_ready path.
//
// Parameters:
//   WIDTH  data width of each input and of the output
//   N      number of selectable inputs (2..16)
//   SEL_W  derived select width, max(1, $clog2(N)); not overridable
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_data    packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        binary select, sampled with in_data on accept
//   in_valid   upstream presents in_data/sel
//   in_ready   block can accept this cycle (registered)
//   out_data   selected word at head of stage (registered)
//   out_valid  out_data valid (registered)
//   out_ready  downstream consumes out_data this cycle
//   sel_err    only with MUX_SEL_CHECK_EN: one-cycle pulse after an accept
//              with sel >= N (registered)
//
// Build option: define MUX_SEL_CHECK_EN to add the sel_err port/check.
// Out-of-range sel always delivers all-zero data.

module pipe_mux_sel #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SEL_W = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic               sel_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_sel_word;
  logic             w_accept;
  logic             w_release;

  // Unmatched select values fall through to the zero default.
  always_comb begin
    w_sel_word = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept  = in_valid & r_in_ready;
  assign w_release = r_out_valid & out_ready;

  // in_ready/out_valid are registered alongside the state so every output
  // comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_sel_word;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_release) begin
            r_main <= w_sel_word;
          end else if (w_accept) begin
            r_skid     <= w_sel_word;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_release) begin
            r_main  <= r_skid;
            r_state <= ST_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_main;
  assign out_valid = r_out_valid;

`ifdef MUX_SEL_CHECK_EN
  logic r_sel_err;
  logic w_sel_ok;

  assign w_sel_ok = (32'(sel) < N);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept & ~w_sel_ok;
    end
  end

  assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_pipe_mux_sel.sv
// tb_pipe_mux_sel
//   Scoreboard bench for pipe_mux_sel. A 4-way instance covers reset,
//   streaming, backpressure, blocked input and reset mid-transfer; a 3-way
//   instance covers the out-of-range select (zero data, optional sel_err).
//   Expected words are pushed by the stimulus; a negedge monitor pops and
//   compares on every release and checks output stability while stalled.

module tb_pipe_mux_sel;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 4-way instance
  logic [4*W-1:0] in_data4;
  logic [1:0]     sel4;
  logic           in_valid4;
  logic           in_ready4;
  logic [W-1:0]   out_data4;
  logic           out_valid4;
  logic           out_ready4;

  // 3-way instance
  logic [3*W-1:0] in_data3;
  logic [1:0]     sel3;
  logic           in_valid3;
  logic           in_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic           out_ready3;

`ifdef MUX_SEL_CHECK_EN
  logic sel_err4;
  logic sel_err3;
`endif

  pipe_mux_sel #(.WIDTH(W), .N(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data4),
    .sel       (sel4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err   (sel_err4)
`endif
  );

  pipe_mux_sel #(.WIDTH(W), .N(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
`ifdef MUX_SEL_CHECK_EN
    ,
    .sel_err   (sel_err3)
`endif
  );

  int unsigned tests  = 0;
  int unsigned failed = 0;

  logic [W-1:0] q4[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: releases pop the scoreboard; stalls must hold data and valid.
  logic         stall_pending = 1'b0;
  logic [W-1:0] stall_data;

  always @(negedge clk) begin
    if (stall_pending && !reset) begin
      chk("stall_valid", {31'b0, out_valid4}, 32'd1);
      chk("stall_data", out_data4, stall_data);
    end
    stall_pending = 1'b0;
    if (!reset && out_valid4) begin
      if (out_ready4) begin
        if (q4.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_out: got 0x%0h expected no output at %0t", out_data4, $time);
        end else begin
          chk("out_data", out_data4, q4.pop_front());
        end
      end else begin
        stall_pending = 1'b1;
        stall_data    = out_data4;
      end
    end
  end

  initial begin
    reset      = 1'b1;
    in_data4   = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    sel4       = '0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b0;
    in_data3   = {32'hC2, 32'hB1, 32'hA0};
    sel3       = '0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", {31'b0, out_valid4}, 32'd0);
      chk("rst_out_data", out_data4, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready4}, 32'd0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready4}, 32'd1);
    chk("post_rst_out_valid", {31'b0, out_valid4}, 32'd0);

    // Streaming, one transfer per cycle
    out_ready4 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_valid4 = 1'b1;
      sel4      = 2'(s);
      case (s)
        0: q4.push_back(32'hA0);
        1: q4.push_back(32'hB1);
        2: q4.push_back(32'hC2);
        default: q4.push_back(32'hD3);
      endcase
      tick();
      chk("stream_in_ready", {31'b0, in_ready4}, 32'd1);
    end
    in_valid4 = 1'b0;
    tick();
    tick();
    chk("stream_drained", {31'b0, out_valid4}, 32'd0);

    // Backpressure into FULL
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    sel4       = 2'd1;
    q4.push_back(32'hB1);
    tick();
    chk("bp_in_ready_one", {31'b0, in_ready4}, 32'd1);
    sel4 = 2'd3;
    q4.push_back(32'hD3);
    tick();
    chk("bp_in_ready_full", {31'b0, in_ready4}, 32'd0);
    chk("bp_head", out_data4, 32'hB1);

    // Blocked input while FULL: sel=2 must not be captured
    sel4 = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("blk_in_ready", {31'b0, in_ready4}, 32'd0);
      chk("blk_head", out_data4, 32'hB1);
    end
    out_ready4 = 1'b1;
    tick();
    chk("rel_in_ready", {31'b0, in_ready4}, 32'd1);
    chk("rel_head", out_data4, 32'hD3);
    q4.push_back(32'hC2);
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    chk("bp_drained", {31'b0, out_valid4}, 32'd0);

    // Reset while FULL: buffered B1/D3 must never appear
    out_ready4 = 1'b0;
    in_valid4  = 1'b1;
    sel4       = 2'd1;
    tick();
    sel4 = 2'd3;
    tick();
    chk("mid_full", {31'b0, in_ready4}, 32'd0);
    in_valid4 = 1'b0;
    reset     = 1'b1;
    tick();
    chk("mid_rst_out_valid", {31'b0, out_valid4}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready4}, 32'd0);
    reset      = 1'b0;
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_post_out_valid", {31'b0, out_valid4}, 32'd0);
    end
    chk("mid_post_in_ready", {31'b0, in_ready4}, 32'd1);

    // Out-of-range select on the 3-way instance
    in_valid3 = 1'b1;
    sel3      = 2'd2;
    tick();
    chk("n3_sel2_valid", {31'b0, out_valid3}, 32'd1);
    chk("n3_sel2_data", out_data3, 32'hC2);
`ifdef MUX_SEL_CHECK_EN
    chk("n3_sel2_err", {31'b0, sel_err3}, 32'd0);
`endif
    sel3 = 2'd3;
    tick();
    in_valid3 = 1'b0;
    chk("n3_oor_valid", {31'b0, out_valid3}, 32'd1);
    chk("n3_oor_data", out_data3, 32'd0);
`ifdef MUX_SEL_CHECK_EN
    chk("n3_oor_err", {31'b0, sel_err3}, 32'd1);
    chk("n4_err_idle", {31'b0, sel_err4}, 32'd0);
`endif
    tick();
    chk("n3_idle_valid", {31'b0, out_valid3}, 32'd0);
`ifdef MUX_SEL_CHECK_EN
    chk("n3_err_pulse_end", {31'b0, sel_err3}, 32'd0);
`endif

    tick();
    chk("scoreboard_empty", 32'(q4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
